morse_letter_decoder: RTL and testbench
=======================================

// Module: morse_letter_decoder
// PURPOSE
//  Parametrised Morse keyer decoder. Samples one debounced key level, times marks and spaces in prescaled ticks,
//  and emits dot/dash, letter-gap and word-gap pulses. It also assembles each letter's symbols into a code/length
//  word with a valid strobe. Sits between the button/debounce stage and the character lookup/display logic.
// PARAMETERS
//  TICK_DIV   1_000_000 clk cycles per time tick (10 ms @ 100 MHz); >=2
//  DASH_TICKS 30        mark of >= this many ticks is a dash, else dot; >=1
//  LG_TICKS   40        space reaching this many ticks ends a letter; >=1
//  WG_TICKS   70        space reaching this many ticks ends a word; > LG_TICKS
//  MAX_SYM    6         max symbols per letter (code width); >=1
// PORTS
//  clk        in  1                      system clock
//  reset_n    in  1                      asynchronous active-low reset
//  b          in  1                      debounced key level, 1 = pressed; asynchronous to clk
//  dot        out 1                      1-cycle pulse: dot classified
//  dash       out 1                      1-cycle pulse: dash classified
//  lg         out 1                      1-cycle pulse: letter gap detected
//  wg         out 1                      1-cycle pulse: word gap detected
//  code_valid out 1                      1-cycle pulse, coincident with lg: code/len/err valid
//  code       out MAX_SYM                symbols, first at MSB of used field, LSB = last; 1 = dash
//  len        out $clog2(MAX_SYM+1)      symbol count of letter (1..MAX_SYM)
//  err        out 1                      letter exceeded MAX_SYM symbols
// BEHAVIOUR
//  - Reset, async on reset_n low:
//    - all outputs 0, state IDLE, counters 0, shift register and length cleared.
//    - A partial letter is discarded; no pulse is emitted on reset release.
//  - b passes through a 2-FF synchroniser plus an edge register, giving p_edge/n_edge 3 clk after b changes.
//  - Tick prescaler:
//    - counts 0..TICK_DIV-1 and pulses tick at TICK_DIV-1;
//    - cleared on every p_edge/n_edge.
//  - Duration counter T:
//    - $clog2(WG_TICKS+1) bits, +1 per tick, saturates at WG_TICKS;
//    - cleared on every p_edge/n_edge;
//    - not cleared at LG.
//  - FSM, 4 states:
//    - IDLE:
//      - p_edge -> MARK.
//    - MARK:
//      - n_edge -> SPACE;
//      - if T < DASH_TICKS: dot, shift in 0; else dash, shift in 1.
//      - A stuck key never times out; T saturates.
//    - SPACE:
//      - p_edge -> MARK; letter continues.
//      - T reaches LG_TICKS -> LGAP; lg and code_valid asserted.
//      - Then the shift register and length are cleared and err is cleared.
//    - LGAP:
//      - p_edge -> MARK; new letter.
//      - T reaches WG_TICKS -> IDLE; wg asserted.
//  - Pulses are registered and asserted the clk after the decision cycle; at most one of dot/dash per mark.
//  - code/len/err hold their last letter value until the next code_valid.
//    - Unused MSBs above len are 0.
//    - Symbols shift left: code = {code[MAX_SYM-2:0], sym}.
//  - Overflow: a symbol arriving with len==MAX_SYM is dropped (dot/dash still pulse) and sets err for that letter.
//    - code_valid still fires, with len=MAX_SYM and err=1.
//  - Simultaneous events: p_edge in the same cycle T reaches LG_TICKS or WG_TICKS -> p_edge wins.
//    - No lg/wg/code_valid is emitted; go to MARK.
//  - Glitches shorter than the sync depth are not filtered; b is required to be debounced upstream.
// TESTING  (TICK_DIV=4, DASH_TICKS=3, LG_TICKS=4, WG_TICKS=8, MAX_SYM=4)
//  1. Letter A: press 8 clk, release 4 clk, press 20 clk, release 40 clk
//     -> dot, dash, then lg+code_valid with code=4'b0001 len=2 err=0, then wg; FSM back in IDLE.
//  2. Five dots, each 8 clk press / 4 clk space
//     -> 5 dot pulses, code_valid with code=4'b0000 len=4 err=1; next letter E gives len=1 err=0.
//  3. Press held 200 clk -> no pulse until release; on release a single dash; no counter wrap.
//  4. reset_n low mid-MARK after 2 dots
//     -> all outputs 0 immediately; after release, letter T (one dash) gives code=4'b0001 len=1.
//  5. p_edge placed on the exact cycle T reaches LG_TICKS -> no lg/code_valid; symbols merge into one letter.
//  6. Letter then space held to 8 ticks
//     -> lg exactly once at T=4, wg exactly once at T=8; no further pulses while idle 1000 clk.

Source files
------------

// File: rtl/morse_letter_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_letter_decoder
//  Purpose  : Morse keyer decoder. Synchronises a debounced key level, times
//             marks and spaces in prescaled ticks, emits dot/dash, letter-gap
//             and word-gap pulses, and assembles each letter into a
//             code/length word with a valid strobe.
//  Ports    : clk        - system clock
//             reset_n    - asynchronous active-low reset
//             b          - debounced key level (1 = pressed), async to clk
//             dot, dash  - 1-cycle symbol classification pulses
//             lg, wg     - 1-cycle letter-gap / word-gap pulses
//             code_valid - 1-cycle strobe with lg, qualifies code/len/err
//             code       - letter symbols, LSB = last symbol, 1 = dash
//             len        - number of symbols in the letter
//             err        - letter had more than MAX_SYM symbols
//  Revision : 1.0 - initial release
// ============================================================================
module morse_letter_decoder #(
  parameter int TICK_DIV   = 1_000_000,
  parameter int DASH_TICKS = 30,
  parameter int LG_TICKS   = 40,
  parameter int WG_TICKS   = 70,
  parameter int MAX_SYM    = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         b,
  output logic                         dot,
  output logic                         dash,
  output logic                         lg,
  output logic                         wg,
  output logic                         code_valid,
  output logic [MAX_SYM-1:0]           code,
  output logic [$clog2(MAX_SYM+1)-1:0] len,
  output logic                         err
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int T_W   = $clog2(WG_TICKS + 1);
  localparam int LEN_W = $clog2(MAX_SYM + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_LGAP  = 2'd3
  } state_t;

  logic               b_s1_q, b_s2_q, b_dly_q;
  logic               w_p_edge, w_n_edge, w_edge;
  logic               w_tick, w_reach_lg, w_reach_wg, w_sym;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [T_W-1:0]     t_q, t_d;
  state_t             state_q, state_d;
  logic [MAX_SYM-1:0] sr_q, sr_d;
  logic [MAX_SYM:0]   w_sr_shift;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               dot_q, dot_d, dash_q, dash_d;
  logic               lg_q, lg_d, wg_q, wg_d, cv_q, cv_d;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               err_q, err_d;

  // Edges are taken between the second synchroniser stage and a delay stage.
  assign w_p_edge = b_s2_q & ~b_dly_q;
  assign w_n_edge = ~b_s2_q & b_dly_q;
  assign w_edge   = w_p_edge | w_n_edge;

  assign w_tick     = (int'(div_q) == TICK_DIV - 1);
  // "Reaches" means the tick that moves T onto the threshold.
  assign w_reach_lg = w_tick && (int'(t_q) == LG_TICKS - 1);
  assign w_reach_wg = w_tick && (int'(t_q) == WG_TICKS - 1);
  assign w_sym      = (int'(t_q) >= DASH_TICKS);
  assign w_sr_shift = {sr_q, w_sym};

  // Prescaler and duration counter, both restarted by any key edge.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (w_edge || w_tick) begin
      div_d = '0;
    end
    t_d = t_q;
    if (w_edge) begin
      t_d = '0;
    end else if (w_tick && (int'(t_q) != WG_TICKS)) begin
      t_d = t_q + T_W'(1);
    end
  end

  // Next-state and registered-output decisions. Key edges are tested before
  // gap thresholds so a press on the threshold cycle suppresses the gap.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    lg_d    = 1'b0;
    wg_d    = 1'b0;
    cv_d    = 1'b0;
    code_d  = code_q;
    len_d   = len_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_p_edge) state_d = S_MARK;
      end
      S_MARK: begin
        if (w_n_edge) begin
          state_d = S_SPACE;
          dot_d   = ~w_sym;
          dash_d  = w_sym;
          if (int'(cnt_q) == MAX_SYM) begin
            ovf_d = 1'b1;               // symbol dropped, letter flagged
          end else begin
            sr_d  = w_sr_shift[MAX_SYM-1:0];
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      S_SPACE: begin
        if (w_p_edge) begin
          state_d = S_MARK;
        end else if (w_reach_lg) begin
          state_d = S_LGAP;
          lg_d    = 1'b1;
          cv_d    = 1'b1;
          code_d  = sr_q;
          len_d   = cnt_q;
          err_d   = ovf_q;
          sr_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LGAP: begin
        if (w_p_edge) begin
          state_d = S_MARK;
        end else if (w_reach_wg) begin
          state_d = S_IDLE;
          wg_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_s1_q  <= 1'b0;
      b_s2_q  <= 1'b0;
      b_dly_q <= 1'b0;
      div_q   <= '0;
      t_q     <= '0;
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      lg_q    <= 1'b0;
      wg_q    <= 1'b0;
      cv_q    <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      b_s1_q  <= b;
      b_s2_q  <= b_s1_q;
      b_dly_q <= b_s2_q;
      div_q   <= div_d;
      t_q     <= t_d;
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      lg_q    <= lg_d;
      wg_q    <= wg_d;
      cv_q    <= cv_d;
      code_q  <= code_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign dot        = dot_q;
  assign dash       = dash_q;
  assign lg         = lg_q;
  assign wg         = wg_q;
  assign code_valid = cv_q;
  assign code       = code_q;
  assign len        = len_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_letter_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_letter_decoder
//  Purpose  : Self-checking bench for morse_letter_decoder. Key activity is
//             described as press/release durations; a duration-based model
//             predicts every pulse and its cycle, and the observed pulse
//             stream is compared against it. Table vectors and hand-written
//             sequences check letter contents and corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morse_letter_decoder;

  localparam int TICK_DIV   = 4;
  localparam int DASH_TICKS = 3;
  localparam int LG_TICKS   = 4;
  localparam int WG_TICKS   = 8;
  localparam int MAX_SYM    = 4;
  localparam int LEN_W      = $clog2(MAX_SYM + 1);
  localparam int SYNC_LAT   = 3;   // key change to decision edge
  localparam int K_DOT = 0, K_DASH = 1, K_LG = 2, K_WG = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic b = 1'b0;
  logic dot, dash, lg, wg, code_valid, err;
  logic [MAX_SYM-1:0] code;
  logic [LEN_W-1:0]   len;

  morse_letter_decoder #(
    .TICK_DIV(TICK_DIV), .DASH_TICKS(DASH_TICKS), .LG_TICKS(LG_TICKS),
    .WG_TICKS(WG_TICKS), .MAX_SYM(MAX_SYM)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .b(b),
    .dot(dot), .dash(dash), .lg(lg), .wg(wg), .code_valid(code_valid),
    .code(code), .len(len), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endfunction

  typedef struct { int kind; int cyc; int code; int len; int err; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int n_pulses = 0, n_lg = 0, n_wg = 0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      ev_t e;
      e.cyc = cyc; e.code = 0; e.len = 0; e.err = 0; e.kind = -1;
      if (dot)  begin e.kind = K_DOT;  obs_q.push_back(e); end
      if (dash) begin e.kind = K_DASH; obs_q.push_back(e); end
      if (lg) begin
        e.kind = K_LG; e.code = int'(code); e.len = int'(len); e.err = int'(err);
        obs_q.push_back(e); n_lg++;
      end
      if (wg) begin e.kind = K_WG; e.code = 0; e.len = 0; e.err = 0; obs_q.push_back(e); n_wg++; end
      if (dot || dash || lg || wg || code_valid) n_pulses++;
      if (lg || code_valid) chk("cv_with_lg", code_valid, lg);
      if (dot || dash) chk("one_symbol_pulse", dot ^ dash, 1);
    end
  end

  // ---------------- duration-based reference model ----------------
  int m_press_d = 0, m_rel_d = 0;
  bit m_in_space = 0;
  int m_syms[$];

  function automatic void push_ev(input int k, input int c, input int cd, input int ln, input int er);
    ev_t e;
    e.kind = k; e.cyc = c; e.code = cd; e.len = ln; e.err = er;
    exp_q.push_back(e);
  endfunction

  // Resolve the space that started at m_rel_d and ended (by a press or the
  // observation horizon) at decision time d. A press landing exactly on a
  // threshold tick wins over the gap.
  function automatic void m_close_space(input int d);
    int ln, cd;
    if (!m_in_space) return;
    if (m_rel_d + LG_TICKS * TICK_DIV < d) begin
      ln = (m_syms.size() > MAX_SYM) ? MAX_SYM : m_syms.size();
      cd = 0;
      for (int i = 0; i < ln; i++) cd = cd * 2 + m_syms[i];
      push_ev(K_LG, m_rel_d + LG_TICKS * TICK_DIV, cd, ln, (m_syms.size() > MAX_SYM) ? 1 : 0);
      m_syms.delete();
      if (m_rel_d + WG_TICKS * TICK_DIV < d) push_ev(K_WG, m_rel_d + WG_TICKS * TICK_DIV, 0, 0, 0);
    end
    m_in_space = 0;
  endfunction

  function automatic void m_press(input int d);
    m_close_space(d);
    m_press_d = d;
  endfunction

  function automatic void m_release(input int d);
    int ticks;
    ticks = (d - m_press_d - 1) / TICK_DIV;
    if (ticks > WG_TICKS) ticks = WG_TICKS;
    push_ev((ticks >= DASH_TICKS) ? K_DASH : K_DOT, d, 0, 0, 0);
    m_syms.push_back((ticks >= DASH_TICKS) ? 1 : 0);
    m_rel_d = d;
    m_in_space = 1;
  endfunction

  function automatic void m_reset();
    m_syms.delete();
    m_in_space = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called #1 after a posedge; holds the new level for n clocks.
  task automatic drive(input logic lvl, input int n);
    b = lvl;
    if (lvl) m_press(cyc + SYNC_LAT);
    else     m_release(cyc + SYNC_LAT);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "_event_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      chk({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      if (exp_q[i].kind == K_LG) begin
        chk({tag, "_code"}, obs_q[i].code, exp_q[i].code);
        chk({tag, "_len"},  obs_q[i].len,  exp_q[i].len);
        chk({tag, "_err"},  obs_q[i].err,  exp_q[i].err);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Only called at least 40 clocks after the last release.
  task automatic flush(input string tag);
    m_close_space(cyc + 1);
    compare_events(tag);
  endtask

  typedef struct { int n; int m[6]; int code; int len; int err; } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input int n, input int m0, input int m1, input int m2, input int m3,
                         input int m4, input int m5, input int cd, input int ln, input int er);
    vec_t v;
    v.n = n; v.m[0] = m0; v.m[1] = m1; v.m[2] = m2; v.m[3] = m3; v.m[4] = m4; v.m[5] = m5;
    v.code = cd; v.len = ln; v.err = er;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0, l0, w0, nsym, mk;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dot", dot, 0);   chk("rst_dash", dash, 0); chk("rst_lg", lg, 0);
    chk("rst_wg", wg, 0);     chk("rst_cv", code_valid, 0);
    chk("rst_code", code, 0); chk("rst_len", len, 0);   chk("rst_err", err, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Table: marks per letter (clk), 4-clk intra gaps, 40-clk closing gap
    add_vec(2,  8, 20,  0,  0,  0,  0, 4'b0001, 2, 0);  // A
    add_vec(5,  8,  8,  8,  8,  8,  0, 4'b0000, 4, 1);  // five dots, overflow
    add_vec(1,  8,  0,  0,  0,  0,  0, 4'b0000, 1, 0);  // E
    add_vec(1, 20,  0,  0,  0,  0,  0, 4'b0001, 1, 0);  // T
    add_vec(4, 20,  8, 20, 20,  0,  0, 4'b1011, 4, 0);  // Y
    add_vec(6,  8, 20, 20, 20, 20,  8, 4'b0111, 4, 1);  // overflow keeps first four
    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        drive(1'b1, tbl[i].m[j]);
        drive(1'b0, (j == tbl[i].n - 1) ? 40 : 4);
      end
      flush("tbl");
      chk("tbl_code_hold", code, tbl[i].code);
      chk("tbl_len_hold",  len,  tbl[i].len);
      chk("tbl_err_hold",  err,  tbl[i].err);
    end

    // Stuck key: nothing until release, then one dash
    p0 = n_pulses;
    drive(1'b1, 200);
    chk("stuck_no_pulse", n_pulses - p0, 0);
    drive(1'b0, 40);
    flush("stuck");
    chk("stuck_code", code, 1);
    chk("stuck_len", len, 1);

    // Press on the exact letter-gap tick merges symbols; one clock later splits
    l0 = n_lg;
    drive(1'b1, 8); drive(1'b0, 16); drive(1'b1, 20); drive(1'b0, 40);
    flush("lg_tie");
    chk("lg_tie_count", n_lg - l0, 1);
    chk("lg_tie_code", code, 4'b0001);
    chk("lg_tie_len", len, 2);
    l0 = n_lg;
    drive(1'b1, 8); drive(1'b0, 17); drive(1'b1, 20); drive(1'b0, 40);
    flush("lg_split");
    chk("lg_split_count", n_lg - l0, 2);
    chk("lg_split_len", len, 1);

    // Single letter then long idle: exactly one lg and one wg, then silence
    l0 = n_lg; w0 = n_wg;
    drive(1'b1, 8); drive(1'b0, 40);
    flush("gaps");
    chk("gaps_lg_once", n_lg - l0, 1);
    chk("gaps_wg_once", n_wg - w0, 1);
    p0 = n_pulses;
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_silent", n_pulses - p0, 0);

    // Reset mid-mark after two dots
    drive(1'b1, 8); drive(1'b0, 4); drive(1'b1, 8); drive(1'b0, 4);
    b = 1'b1;
    m_press(cyc + SYNC_LAT);
    repeat (6) @(posedge clk);
    #1;
    compare_events("pre_reset");
    reset_n = 1'b0;
    #1;
    chk("arst_dot", dot, 0);   chk("arst_dash", dash, 0); chk("arst_lg", lg, 0);
    chk("arst_wg", wg, 0);     chk("arst_cv", code_valid, 0);
    chk("arst_code", code, 0); chk("arst_len", len, 0);   chk("arst_err", err, 0);
    b = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    p0 = n_pulses;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_release_silent", n_pulses - p0, 0);
    drive(1'b1, 20); drive(1'b0, 40);
    flush("after_reset");
    chk("after_reset_code", code, 4'b0001);
    chk("after_reset_len", len, 1);
    chk("after_reset_err", err, 0);

    // Randomised letters against the duration model
    for (int l = 0; l < 25; l++) begin
      nsym = $urandom_range(1, 6);
      for (int j = 0; j < nsym; j++) begin
        mk = ($urandom_range(0, 9) == 0) ? $urandom_range(41, 80) : $urandom_range(2, 40);
        drive(1'b1, mk);
        if (j < nsym - 1)      drive(1'b0, $urandom_range(2, 16));
        else if (l < 24)       drive(1'b0, $urandom_range(17, 45));
        else                   drive(1'b0, 40);
      end
    end
    flush("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
